// File: rtl/ypc_pkg.sv
// Shared definitions for the YPC core sequencer.
//   ypc_state_t : sequencer FSM states
//   INST_BYTES  : PC step per instruction
//   next_pc()   : sequential PC (32-bit wrap)
package ypc_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4,
    ERR    = 3'd5
  } ypc_state_t;

  localparam int unsigned INST_BYTES = 4;

  // Plain 32-bit add; 32'hFFFF_FFFC rolls over to 0.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'(INST_BYTES);
  endfunction

endpackage

// File: rtl/ypc_seq_ctrl.sv
// Multi-cycle sequencer for the YPC core datapath.
// Owns the PC, fetches over a req/valid handshake, latches the instruction
// for the decoder, strobes the ALU capture and the register-file write, and
// stops on ebreak (halt) or on a fetch that never answers (fetch_err).
//
// Ports
//   clk          core clock
//   reset        synchronous, active-low (0 = reset)
//   imem_req     fetch request, held until imem_rvalid
//   imem_addr    fetch address (= pc)
//   imem_rvalid  fetch data valid
//   imem_rdata   fetched instruction
//   inst         latched instruction to the decoder
//   dec_isbreak  decoder: inst is ebreak
//   dec_regwen   decoder: inst writes rd
//   alu_en       one-cycle ALU result capture strobe (EXEC)
//   rf_wen       one-cycle register-file write strobe (WB && dec_regwen)
//   pc           current PC
//   retired      completed non-ebreak instructions
//   halt         sticky, ebreak executed
//   fetch_err    sticky, fetch timeout
module ypc_seq_ctrl
  import ypc_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned TIMEOUT_W = 4,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      inst,
  input  logic             dec_isbreak,
  input  logic             dec_regwen,
  output logic             alu_en,
  output logic             rf_wen,
  output logic [31:0]      pc,
  output logic [CNT_W-1:0] retired,
  output logic             halt,
  output logic             fetch_err
);

  // Last wait count before the fetch is declared dead.
  localparam logic [TIMEOUT_W-1:0] WAIT_MAX = '1;

  ypc_state_t           state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          inst_q, inst_d;
  logic [CNT_W-1:0]     retired_q, retired_d;
  logic                 halt_q, halt_d;
  logic                 ferr_q, ferr_d;
  logic [TIMEOUT_W-1:0] wait_q, wait_d;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      retired_q <= '0;
      halt_q    <= 1'b0;
      ferr_q    <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      retired_q <= retired_d;
      halt_q    <= halt_d;
      ferr_q    <= ferr_d;
      wait_q    <= wait_d;
    end
  end

  // Next state and strobes
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    retired_d = retired_q;
    halt_d    = halt_q;
    ferr_d    = ferr_q;
    wait_d    = wait_q;
    imem_req  = 1'b0;
    alu_en    = 1'b0;
    rf_wen    = 1'b0;

    unique case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_rvalid) begin
          // Zero-wait fetch is legal: data may arrive in the request cycle.
          inst_d  = imem_rdata;
          wait_d  = '0;
          state_d = DECODE;
        end else if (wait_q == WAIT_MAX) begin
          ferr_d  = 1'b1;
          wait_d  = '0;
          state_d = ERR;
        end else begin
          wait_d = wait_q + TIMEOUT_W'(1);
        end
      end
      DECODE: begin
        // Decoder outputs have had a full cycle to settle on inst_q.
        if (dec_isbreak) begin
          halt_d  = 1'b1;
          state_d = HALT;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_en  = 1'b1;
        state_d = WB;
      end
      WB: begin
        rf_wen    = dec_regwen;
        pc_d      = next_pc(pc_q);
        retired_d = retired_q + CNT_W'(1);
        state_d   = FETCH;
      end
      HALT, ERR: begin
        state_d = state_q;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    // Strobes are quiet while reset is asserted, whatever state is held.
    if (!reset) begin
      imem_req = 1'b0;
      alu_en   = 1'b0;
      rf_wen   = 1'b0;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign inst      = inst_q;
  assign retired   = retired_q;
  assign halt      = halt_q;
  assign fetch_err = ferr_q;

endmodule

// File: tb/tb_ypc_seq_ctrl.sv
// Bench for ypc_seq_ctrl: two instances (RESET_PC 0 and 32'hFFFF_FFFC) share
// stimulus; a phase-level model predicts every output each cycle, and
// directed scenarios add hand-computed literal checks.
module tb_ypc_seq_ctrl;

  localparam logic [31:0] PC1    = 32'hFFFF_FFFC;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'h0;
  logic        dec_isbreak, dec_regwen;

  logic        req0, req1, alu0, alu1, rf0, rf1, halt0, halt1, err0, err1;
  logic [31:0] addr0, addr1, inst0, inst1, pc0, pc1, ret0, ret1;

  ypc_seq_ctrl #(.RESET_PC(32'h0), .TIMEOUT_W(4), .CNT_W(32)) u0 (
    .clk(clk), .reset(reset), .imem_req(req0), .imem_addr(addr0),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst(inst0),
    .dec_isbreak(dec_isbreak), .dec_regwen(dec_regwen), .alu_en(alu0),
    .rf_wen(rf0), .pc(pc0), .retired(ret0), .halt(halt0), .fetch_err(err0));

  ypc_seq_ctrl #(.RESET_PC(PC1), .TIMEOUT_W(4), .CNT_W(32)) u1 (
    .clk(clk), .reset(reset), .imem_req(req1), .imem_addr(addr1),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst(inst1),
    .dec_isbreak(dec_isbreak), .dec_regwen(dec_regwen), .alu_en(alu1),
    .rf_wen(rf1), .pc(pc1), .retired(ret1), .halt(halt1), .fetch_err(err1));

  // Stand-in decoder
  assign dec_isbreak = (inst0 == EBREAK);
  assign dec_regwen  = (inst0[6:0] == 7'b0010011);

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: answers 'lat' wait cycles after the request rises
  // (lat<0 = never); force_rv drives a stray valid with junk data.
  logic [31:0] rom [0:15];
  int lat = 0;
  bit force_rv = 1'b0;
  int wcnt = 0;
  always @(negedge clk) begin
    if (force_rv) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end else if (req0 && lat >= 0 && wcnt == lat) begin
      imem_rvalid = 1'b1;
      imem_rdata  = rom[addr0[5:2]];
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    wcnt = (req0 && !imem_rvalid) ? wcnt + 1 : 0;
  end

  // Model: m_ph counts cycles since the instruction was accepted (0 = still
  // fetching); pc is never stored, it is RESET_PC + 4 * retired.
  int          m_ph = 0;
  int          m_idle = 0;
  logic [31:0] m_inst = 32'h0;
  logic [31:0] m_ret = 32'h0;
  bit          m_halt = 1'b0;
  bit          m_err = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_ph <= 0; m_idle <= 0; m_inst <= 32'h0; m_ret <= 32'h0;
      m_halt <= 1'b0; m_err <= 1'b0;
    end else if (!m_halt && !m_err) begin
      case (m_ph)
        0: if (imem_rvalid) begin
             m_inst <= imem_rdata; m_ph <= 1; m_idle <= 0;
           end else if (m_idle == 15) begin
             m_err <= 1'b1; m_idle <= 0;
           end else begin
             m_idle <= m_idle + 1;
           end
        1: if (dec_isbreak) m_halt <= 1'b1; else m_ph <= 2;
        2: m_ph <= 3;
        default: begin m_ret <= m_ret + 32'd1; m_ph <= 0; end
      endcase
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      logic act;
      act = reset && !m_halt && !m_err;
      chk("req0",  {31'b0, req0},  {31'b0, act && m_ph == 0});
      chk("req1",  {31'b0, req1},  {31'b0, act && m_ph == 0});
      chk("alu0",  {31'b0, alu0},  {31'b0, act && m_ph == 2});
      chk("alu1",  {31'b0, alu1},  {31'b0, act && m_ph == 2});
      chk("rf0",   {31'b0, rf0},   {31'b0, act && m_ph == 3 && dec_regwen});
      chk("rf1",   {31'b0, rf1},   {31'b0, act && m_ph == 3 && dec_regwen});
      chk("pc0",   pc0,   m_ret << 2);
      chk("addr0", addr0, m_ret << 2);
      chk("pc1",   pc1,   PC1 + (m_ret << 2));
      chk("addr1", addr1, PC1 + (m_ret << 2));
      chk("inst0", inst0, m_inst);
      chk("inst1", inst1, m_inst);
      chk("ret0",  ret0,  m_ret);
      chk("ret1",  ret1,  m_ret);
      chk("halt0", {31'b0, halt0}, {31'b0, m_halt});
      chk("halt1", {31'b0, halt1}, {31'b0, m_halt});
      chk("err0",  {31'b0, err0},  {31'b0, m_err});
      chk("err1",  {31'b0, err1},  {31'b0, m_err});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
  endtask

  // Called at posedge+2; afterwards the bench is inside cycle 1.
  task automatic do_release();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    logic [31:0] mask;
    int          nreq, first_err;

    for (int i = 0; i < 16; i++) rom[i] = 32'h0000_0013;
    rom[0] = 32'h0010_0093;   // addi x1,x0,1
    rom[1] = 32'h0020_8113;   // addi x2,x1,2
    rom[2] = EBREAK;

    // 1. Reset held for 3 clocks
    reset = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    step();
    chk("rst_req",  {31'b0, req0},  32'd0);
    chk("rst_pc",   pc0,            32'h0);
    chk("rst_pc1",  pc1,            PC1);
    chk("rst_halt", {31'b0, halt0}, 32'd0);
    chk("rst_ret",  ret0,           32'd0);

    // 2. Zero-wait stream ending in ebreak
    lat = 0;
    do_release();
    chk("c1_req",  {31'b0, req0}, 32'd1);
    chk("c1_addr", addr0,         32'h0);
    mask = 32'h0;
    for (int c = 1; c <= 12; c++) begin
      if (rf0) mask[c] = 1'b1;
      step();
    end
    chk("zw_rfmask", mask,           32'h0000_0110);
    chk("zw_ret",    ret0,           32'd2);
    chk("zw_halt",   {31'b0, halt0}, 32'd1);
    chk("zw_pc",     pc0,            32'h8);
    chk("zw_pc1",    pc1,            32'h4);
    chk("zw_inst",   inst0,          EBREAK);
    chk("zw_req",    {31'b0, req0},  32'd0);

    // 3. Three wait cycles before data
    lat = 3;
    do_reset();
    do_release();
    for (int c = 1; c <= 8; c++) begin
      if (c <= 4) begin
        chk("ws_addr", addr0, 32'h0);
        chk("ws_inst_old", inst0, 32'h0);
      end else begin
        chk("ws_inst_new", inst0, 32'h0010_0093);
      end
      step();
    end
    chk("ws_ret", ret0, 32'd1);
    chk("ws_pc",  pc0,  32'h4);

    // 4. Fetch never answered
    lat = -1;
    do_reset();
    do_release();
    nreq = 0;
    first_err = 0;
    for (int c = 1; c <= 20; c++) begin
      if (req0) nreq++;
      if (err0 && first_err == 0) first_err = c;
      step();
    end
    chk("to_nreq",  nreq,           32'd16);
    chk("to_first", first_err,      32'd17);
    chk("to_err",   {31'b0, err0},  32'd1);
    chk("to_halt",  {31'b0, halt0}, 32'd0);
    chk("to_req",   {31'b0, req0},  32'd0);

    // 5. Reset during a fetch wait, stale valid while in reset
    lat = 1;
    do_reset();
    do_release();
    for (int c = 1; c <= 5; c++) step();
    chk("mf_pc",  pc0,           32'h4);
    chk("mf_req", {31'b0, req0}, 32'd1);
    reset = 1'b0;
    force_rv = 1'b1;
    step();
    step();
    force_rv = 1'b0;
    lat = -1;
    do_release();
    chk("mf_pc_rst", pc0,           32'h0);
    chk("mf_inst",   inst0,         32'h0);
    chk("mf_ret",    ret0,          32'd0);
    chk("mf_req2",   {31'b0, req0}, 32'd1);
    step();
    chk("mf_inst2",  inst0,         32'h0);

    // 6. PC wrap and stray valid during EXEC
    lat = 0;
    do_reset();
    do_release();
    step();
    step();
    force_rv = 1'b1;
    chk("pw_alu", {31'b0, alu0}, 32'd1);
    step();
    force_rv = 1'b0;
    chk("pw_inst", inst0, 32'h0010_0093);
    chk("pw_pc1_wb", pc1, PC1);
    step();
    chk("pw_pc1",  pc1,   32'h0);
    chk("pw_pc0",  pc0,   32'h4);
    chk("pw_inst2", inst1, 32'h0010_0093);

    chk_en = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
